bit_serializer: RTL
===================

# bit_serializer

- Parallel-to-serial stage that feeds the `fsm_1010` sequence detector.
- Accepts a word of up to WIDTH bits, with a bit count, over a valid/ready handshake.
- Shifts the word out one bit per clock on `ser_out`, which drives the detector's `in` port directly.
- Back-to-back words stream with no idle bit between them, so detector patterns can span word boundaries.

## Interface
- `WIDTH`, 8: maximum word length in bits; legal range is 2..32.
- `LEN_W`, 6: width of `load_len`; must satisfy 2^LEN_W > WIDTH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load_valid`  in  1  upstream offers a word.
- `load_ready`  out  1  block can accept a word this cycle.
- `load_data`  in  WIDTH  word to send, right-aligned; bits above the length are ignored.
- `load_len`  in  LEN_W  number of bits to send. 0 or any value > WIDTH is treated as WIDTH.
- `ser_out`  out  1  serial bit, connected to the detector's `in`.
- `ser_valid`  out  1  `ser_out` carries a payload bit this cycle.
- `done`  out  1  one-cycle pulse coinciding with the final bit of a word.
- `busy`  out  1  a word is being shifted.

## Operation
- Two states:
  - IDLE:
    - `load_ready`=1.
    - A handshake (`load_valid` and `load_ready` high at a rising edge) latches data into the shift register and the effective length into the remaining-bit counter.
    - Next state is SHIFT.
  - SHIFT:
    - Each cycle presents one bit and decrements the counter.
    - When the counter is 1, the current bit is the last one.
    - If no new handshake occurs on that edge, the next state is IDLE.
- Bit order without the macro is MSB-first within the effective length. For len=N, bits go out in the order `load_data[N-1]`, `load_data[N-2]`, …, `load_data[0]`.
- `load_ready` = IDLE, or (SHIFT and counter==1). A word can therefore be accepted during the last bit of the previous word.
- Back-to-back words:
  - A handshake during the last-bit cycle loads the new word.
  - The first bit of the new word appears on the next cycle.
  - The state stays SHIFT and `ser_valid` stays 1 with no gap.
- `done` = SHIFT and counter==1. It is a registered-state decode and has no combinational path from the inputs.
- `busy` = SHIFT.
- `ser_out` = 0 whenever `ser_valid`=0. The detector sees a 0 stream while the block is idle.
- Length handling:
  - Effective length = (`load_len`==0 or `load_len`>WIDTH) ? WIDTH : `load_len`.
  - The counter is LEN_W bits wide and never wraps below 1 while in SHIFT.
- `load_valid` while `load_ready`=0 is ignored. Upstream holds the word until ready; no data is lost.
- Reset:
  - `rst_n` low clears everything immediately, regardless of clock: state to IDLE, counter 0, shift register 0, `ser_out` 0, `ser_valid` 0, `done` 0, `busy` 0.
  - A word in flight is discarded and is not resumed after reset.
  - `load_ready` decodes to 1 while in reset, but no handshake completes until `rst_n` is high at a rising edge.

## Timing
- Latency: a handshake at edge k puts the first bit on `ser_out`, with `ser_valid`=1, after edge k and through edge k+1.
- A word of length N occupies exactly N consecutive cycles. `done` is high only in the Nth.
- Throughput is one bit per clock, sustained, with no bubbles across words.
- Outputs are registered or state-decoded and are stable for the whole cycle.
- Deassertion of `rst_n` is synchronised by the integrating level. The first edge with `rst_n` high may accept a word.

## Configuration
- `BIT_SERIALIZER_LSB_FIRST_EN`:
  - Defined: bits go out LSB-first, in the order `load_data[0]`, `load_data[1]`, …, `load_data[N-1]`. Length, handshake and timing are unchanged.
  - Undefined (default): MSB-first as described above.

## Test plan
- Reset mid-word: load 8'hA5 with len 8, then pull `rst_n` low after 3 bits. Outputs go to 0 asynchronously. After release, `load_ready`=1, and the next word starts clean with no leftover bits.
- Full word: load 8'b1010_1010 with len 8. `ser_out` is 1,0,1,0,1,0,1,0 on cycles 1..8 and `done` pulses in cycle 8. The downstream `fsm_1010` detects 1010 twice.
- Short and clamped lengths:
  - 8'hFD with len 3: output is 1,0,1, then `ser_valid` drops.
  - len 0: sends 8 bits.
  - len 12: sends 8 bits.
- Back-to-back: hold `load_valid` high with words 4'b1010 (len 4) and 3'b101 (len 3). The output is 7 contiguous bits, 1,0,1,0,1,0,1, with `done` in cycles 4 and 7 and `ser_valid` never dropping.
- Stall: assert `load_valid` during cycle 2 of a len-5 word. It is not accepted until cycle 5, and the data is held stable by the bench throughout.
- Macro defined: load 8'h0B with len 4. Output is 1,1,0,1 (LSB-first). Without the macro the output is 1,0,1,1.

Source files
------------

// File: rtl/bit_serializer_if.sv
// ============================================================================
// Module   : bit_serializer_if
// Purpose  : Load handshake and serial output bundle for bit_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 6
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic             busy;

    modport master (
        output load_valid, load_data, load_len,
        input  load_ready, ser_out, ser_valid, done, busy
    );

    modport slave (
        input  load_valid, load_data, load_len,
        output load_ready, ser_out, ser_valid, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial stage feeding the fsm_1010 detector; streams
//            back-to-back words with no idle bit. Define
//            BIT_SERIALIZER_LSB_FIRST_EN for LSB-first order (default MSB-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serializer_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(WIDTH);

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shreg;

    logic             w_last;
    logic             w_ready;
    logic             w_take;
    logic [LEN_W-1:0] w_eff_len;
    logic [WIDTH-1:0] w_load_word;
    logic [WIDTH-1:0] w_next_shreg;
    logic             w_bit;

    assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LEN_W'(1));
    assign w_ready   = (r_state == ST_IDLE) || w_last;
    assign w_take    = bus.load_valid && w_ready;
    assign w_eff_len = ((bus.load_len == '0) || (bus.load_len > c_MAX_LEN))
                       ? c_MAX_LEN : bus.load_len;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    // Bits above the length are never reached, so no masking is needed.
    assign w_load_word  = bus.load_data;
    assign w_next_shreg = r_shreg >> 1;
    assign w_bit        = r_shreg[0];
`else
    // Left-justify the effective word so its top bit sits at the MSB.
    assign w_load_word  = bus.load_data << (c_MAX_LEN - w_eff_len);
    assign w_next_shreg = r_shreg << 1;
    assign w_bit        = r_shreg[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else if (w_take) begin
            r_state <= ST_SHIFT;
            r_cnt   <= w_eff_len;
            r_shreg <= w_load_word;
        end else if (r_state == ST_SHIFT) begin
            if (w_last) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_shreg <= '0;
            end else begin
                r_cnt   <= r_cnt - LEN_W'(1);
                r_shreg <= w_next_shreg;
            end
        end
    end

    // All outputs decode registered state only; no input-to-output path.
    assign bus.load_ready = w_ready;
    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.ser_valid  = (r_state == ST_SHIFT);
    assign bus.done       = w_last;
    assign bus.ser_out    = (r_state == ST_SHIFT) && w_bit;

endmodule

`default_nettype wire
